// File: rtl/shift_sequencer.sv
// Multi-cycle right shifter: accepts an operand, applies up to STEP bits per clock,
// and returns the result plus the last bit shifted out over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// SHIFT | applying steps until the remaining count reaches zero
// DONE  | result held on out/cout until drained or aborted
module shift_sequencer #(
  parameter int N    = 8,
  parameter int STEP = 2,
  parameter int SHW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [SHW-1:0] shift,
  input  logic           arith,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out,
  output logic           cout,
  output logic           busy
);

  localparam int RW = $clog2(N + 2);
  localparam logic [RW-1:0] STEP_K = RW'(STEP);
  localparam logic [RW-1:0] REM_MAX = RW'(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [RW-1:0] rem;
  logic          fill;

  logic           accept;
  logic [N-1:0]   src;
  logic           src_fill;
  logic [RW-1:0]  src_rem;
  logic [RW-1:0]  k;
  logic [RW-1:0]  rem_next;
  logic [2*N-1:0] ext;
  logic [2*N-1:0] ext_sh;
  logic [N-1:0]   step_out;
  logic           step_cout;

  // The accept edge performs the first step directly on the incoming operand.
  always_comb begin
    accept   = (state == IDLE) && in_valid && !abort;
    src      = accept ? in_a : out;
    src_fill = accept ? (arith & in_a[N-1]) : fill;
    if (!accept)
      src_rem = rem;
    else if (32'(shift) > 32'(N + 1))
      src_rem = REM_MAX;
    else
      src_rem = RW'(shift);
    k         = (src_rem > STEP_K) ? STEP_K : src_rem;
    ext       = {{N{src_fill}}, src};
    ext_sh    = ext >> (k - RW'(1));
    step_out  = ext_sh[N:1];
    step_cout = ext_sh[0];
    rem_next  = src_rem - k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      rem       <= '0;
      fill      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fill     <= src_fill;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (k == '0) begin
              out       <= in_a;
              cout      <= 1'b0;
              rem       <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              out  <= step_out;
              cout <= step_cout;
              rem  <= rem_next;
              if (rem_next == '0) begin
                state     <= DONE;
                out_valid <= 1'b1;
              end else begin
                state <= SHIFT;
              end
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            rem      <= '0;
          end else begin
            out  <= step_out;
            cout <= step_cout;
            rem  <= rem_next;
            if (rem_next == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed operations with literal expectations plus a
// cycle-level reference model compared against the DUT on every clock.
module tb_shift_sequencer;

  localparam int N    = 8;
  localparam int STEP = 2;
  localparam int SHW  = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [SHW-1:0] shift;
  logic           arith;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out;
  logic           cout;
  logic           busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.N(N), .STEP(STEP), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .shift(shift), .arith(arith), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result from the shift definition: bit i of the result is bit (i+eff) of the
  // operand extended upward with the fill bit; cout is bit (eff-1).
  function automatic void ref_calc(input logic [N-1:0] a, input logic [SHW-1:0] sh,
                                   input logic ar, output logic [N-1:0] o,
                                   output logic c, output int lat);
    int eff;
    logic f;
    eff = (int'(sh) > N + 1) ? N + 1 : int'(sh);
    f = ar & a[N-1];
    o = '0;
    if (eff == 0) begin
      o = a;
      c = 1'b0;
      lat = 1;
    end else begin
      for (int i = 0; i < N; i++) o[i] = (i + eff < N) ? a[i+eff] : f;
      c = (eff - 1 < N) ? a[eff-1] : f;
      lat = (eff + STEP - 1) / STEP;
    end
  endfunction

  int         m_phase = 0;
  int         m_left  = 0;
  logic [N-1:0] m_out;
  logic       m_cout;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid && !abort) begin
             ref_calc(in_a, shift, arith, m_out, m_cout, m_left);
             m_left--;
             m_phase = (m_left == 0) ? 2 : 1;
           end
        1: if (abort) m_phase = 0;
           else begin
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (abort || out_ready) m_phase = 0;
      endcase
    end
    #1;
    chk("model in_ready", 32'(in_ready), 32'(m_phase == 0));
    chk("model out_valid", 32'(out_valid), 32'(m_phase == 2));
    chk("model busy", 32'(busy), 32'(m_phase != 0));
    if (m_phase == 2) begin
      chk("model out", 32'(out), 32'(m_out));
      chk("model cout", 32'(cout), 32'(m_cout));
    end
  end

  task automatic do_op(input string nm, input logic [N-1:0] a, input logic [SHW-1:0] sh,
                       input logic ar, input logic [N-1:0] eo, input logic ec,
                       input int el, input int hold);
    logic [N-1:0] mo;
    logic mc;
    int ml, lat;
    ref_calc(a, sh, ar, mo, mc, ml);
    chk({nm, " ref out"}, 32'(mo), 32'(eo));
    chk({nm, " ref cout"}, 32'(mc), 32'(ec));
    chk({nm, " ref lat"}, 32'(ml), 32'(el));
    @(negedge clk);
    chk({nm, " in_ready before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; shift = sh; arith = ar;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'($urandom); shift = 4'($urandom); arith = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " out"}, 32'(out), 32'(eo));
    chk({nm, " cout"}, 32'(cout), 32'(ec));
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({nm, " hold out"}, 32'(out), 32'(eo));
      chk({nm, " hold cout"}, 32'(cout), 32'(ec));
      chk({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " drain out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " drain in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, " idle out kept"}, 32'(out), 32'(eo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; shift = '0; arith = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset out", 32'(out), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("lsr1",  8'hF0, 4'd1,  1'b0, 8'h78, 1'b0, 1, 0);
    do_op("lsr3",  8'hF0, 4'd3,  1'b0, 8'h1E, 1'b0, 2, 0);
    do_op("lsr6",  8'hF0, 4'd6,  1'b0, 8'h03, 1'b1, 3, 0);
    do_op("asr3",  8'hF0, 4'd3,  1'b1, 8'hFE, 1'b0, 2, 0);
    do_op("asr15", 8'hF0, 4'd15, 1'b1, 8'hFF, 1'b1, 5, 0);
    do_op("lsr0",  8'hF0, 4'd0,  1'b0, 8'hF0, 1'b0, 1, 0);
    do_op("lsr8",  8'hF0, 4'd8,  1'b0, 8'h00, 1'b1, 4, 0);
    do_op("lsr9",  8'hF0, 4'd9,  1'b0, 8'h00, 1'b0, 5, 0);
    do_op("lsr5b", 8'hB5, 4'd5,  1'b0, 8'h05, 1'b1, 3, 0);
    do_op("asr2p", 8'h69, 4'd2,  1'b1, 8'h1A, 1'b0, 1, 0);
    do_op("bpres", 8'hF0, 4'd6,  1'b0, 8'h03, 1'b1, 3, 5);

    // abort while idle blocks the accept
    @(negedge clk);
    in_valid = 1'b1; abort = 1'b1; in_a = 8'hF0; shift = 4'd3; arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk("idle abort busy", 32'(busy), 32'd0);
    chk("idle abort in_ready", 32'(in_ready), 32'd1);

    // abort after the first step of a three-step shift
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hF0; shift = 4'd6; arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b1;
    chk("abort pre busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort no out_valid", 32'(out_valid), 32'd0);
    end
    do_op("post_abort", 8'hF0, 4'd3, 1'b1, 8'hFE, 1'b0, 2, 0);

    // asynchronous reset in the middle of a shift
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hF0; shift = 4'd9; arith = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out", 32'(out), 32'd0);
    chk("async reset cout", 32'(cout), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_reset", 8'hF0, 4'd6, 1'b0, 8'h03, 1'b1, 3, 0);

    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
